// File: rtl/camellia_sbox_bank.sv
// camellia_sbox_bank: multi-lane Camellia S-box lookup pipeline with valid/ready backpressure
module camellia_sbox_bank #(
    parameter int LANES     = 8,
    parameter int OUT_REG   = 1,
    parameter int FIXED_MAP = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic [2*LANES-1:0] in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data
);
    localparam logic [7:0] SBOX1 [256] = '{
        8'h70, 8'h82, 8'h2C, 8'hEC, 8'hB3, 8'h27, 8'hC0, 8'hE5, 8'hE4, 8'h85, 8'h57, 8'h35, 8'hEA, 8'h0C, 8'hAE, 8'h41,
        8'h23, 8'hEF, 8'h6B, 8'h93, 8'h45, 8'h19, 8'hA5, 8'h21, 8'hED, 8'h0E, 8'h4F, 8'h4E, 8'h1D, 8'h65, 8'h92, 8'hBD,
        8'h86, 8'hB8, 8'hAF, 8'h8F, 8'h7C, 8'hEB, 8'h1F, 8'hCE, 8'h3E, 8'h30, 8'hDC, 8'h5F, 8'h5E, 8'hC5, 8'h0B, 8'h1A,
        8'hA6, 8'hE1, 8'h39, 8'hCA, 8'hD5, 8'h47, 8'h5D, 8'h3D, 8'hD9, 8'h01, 8'h5A, 8'hD6, 8'h51, 8'h56, 8'h6C, 8'h4D,
        8'h8B, 8'h0D, 8'h9A, 8'h66, 8'hFB, 8'hCC, 8'hB0, 8'h2D, 8'h74, 8'h12, 8'h2B, 8'h20, 8'hF0, 8'hB1, 8'h84, 8'h99,
        8'hDF, 8'h4C, 8'hCB, 8'hC2, 8'h34, 8'h7E, 8'h76, 8'h05, 8'h6D, 8'hB7, 8'hA9, 8'h31, 8'hD1, 8'h17, 8'h04, 8'hD7,
        8'h14, 8'h58, 8'h3A, 8'h61, 8'hDE, 8'h1B, 8'h11, 8'h1C, 8'h32, 8'h0F, 8'h9C, 8'h16, 8'h53, 8'h18, 8'hF2, 8'h22,
        8'hFE, 8'h44, 8'hCF, 8'hB2, 8'hC3, 8'hB5, 8'h7A, 8'h91, 8'h24, 8'h08, 8'hE8, 8'hA8, 8'h60, 8'hFC, 8'h69, 8'h50,
        8'hAA, 8'hD0, 8'hA0, 8'h7D, 8'hA1, 8'h89, 8'h62, 8'h97, 8'h54, 8'h5B, 8'h1E, 8'h95, 8'hE0, 8'hFF, 8'h64, 8'hD2,
        8'h10, 8'hC4, 8'h00, 8'h48, 8'hA3, 8'hF7, 8'h75, 8'hDB, 8'h8A, 8'h03, 8'hE6, 8'hDA, 8'h09, 8'h3F, 8'hDD, 8'h94,
        8'h87, 8'h5C, 8'h83, 8'h02, 8'hCD, 8'h4A, 8'h90, 8'h33, 8'h73, 8'h67, 8'hF6, 8'hF3, 8'h9D, 8'h7F, 8'hBF, 8'hE2,
        8'h52, 8'h9B, 8'hD8, 8'h26, 8'hC8, 8'h37, 8'hC6, 8'h3B, 8'h81, 8'h96, 8'h6F, 8'h4B, 8'h13, 8'hBE, 8'h63, 8'h2E,
        8'hE9, 8'h79, 8'hA7, 8'h8C, 8'h9F, 8'h6E, 8'hBC, 8'h8E, 8'h29, 8'hF5, 8'hF9, 8'hB6, 8'h2F, 8'hFD, 8'hB4, 8'h59,
        8'h78, 8'h98, 8'h06, 8'h6A, 8'hE7, 8'h46, 8'h71, 8'hBA, 8'hD4, 8'h25, 8'hAB, 8'h42, 8'h88, 8'hA2, 8'h8D, 8'hFA,
        8'h72, 8'h07, 8'hB9, 8'h55, 8'hF8, 8'hEE, 8'hAC, 8'h0A, 8'h36, 8'h49, 8'h2A, 8'h68, 8'h3C, 8'h38, 8'hF1, 8'hA4,
        8'h40, 8'h28, 8'hD3, 8'h7B, 8'hBB, 8'hC9, 8'h43, 8'hC1, 8'h15, 8'hE3, 8'hAD, 8'hF4, 8'h77, 8'hC7, 8'h80, 8'h9E
    };
    // F-function box order for lanes 0..7 (s1,s2,s3,s4,s2,s3,s4,s1), lane 0 in the low bits
    localparam logic [15:0] FMAP = {2'd0, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0};

    logic [8*LANES-1:0] lut;
    logic [8*LANES-1:0] d1;
    logic               v1;
    logic               ready1;
    logic               ready_down;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [1:0] sel;
        logic [7:0] x;
        logic [7:0] rom;
        assign sel = (FIXED_MAP != 0) ? FMAP[2*(i%8) +: 2] : in_sel[2*i +: 2];
        assign x   = in_data[8*i +: 8];
        // s4 rotates the address, s2/s3 rotate the looked-up byte
        assign rom = SBOX1[(sel == 2'd3) ? {x[6:0], x[7]} : x];
        assign lut[8*i +: 8] = (sel == 2'd1) ? {rom[6:0], rom[7]} :
                               (sel == 2'd2) ? {rom[0], rom[7:1]} : rom;
    end

    if (FIXED_MAP != 0) begin : g_fixed
        logic unused_sel;
        assign unused_sel = ^in_sel;
    end

    assign ready1   = !v1 || ready_down;
    assign in_ready = ready1;

    // stage 1: capture the finished lane bytes whenever a beat is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (ready1) begin
            v1 <= in_valid;
            if (in_valid) d1 <= lut;
        end
    end

    if (OUT_REG != 0) begin : g_out
        logic               v2;
        logic [8*LANES-1:0] d2;
        assign ready_down = !v2 || out_ready;
        assign out_valid  = v2;
        assign out_data   = d2;
        // stage 2: plain retiming register, holds while the consumer stalls
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else if (ready_down) begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end
    end else begin : g_direct
        assign ready_down = out_ready;
        assign out_valid  = v1;
        assign out_data   = d1;
    end
endmodule

// File: tb/tb_camellia_sbox_bank.sv
// tb_camellia_sbox_bank: directed checks of the S-box bank in OUT_REG=1, OUT_REG=0 and FIXED_MAP=1 forms
module tb_camellia_sbox_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_ready = 1'b1;
    logic        v_m = 1'b0, v_z = 1'b0, v_f = 1'b0;
    logic [63:0] in_data = '0;
    logic [15:0] in_sel = '0;
    logic        ir_m, ov_m, ir_z, ov_z, ir_f, ov_f;
    logic [63:0] od_m, od_z, od_f;
    int          checks = 0;
    int          passes = 0;
    int          sb [256] = '{
        112,130, 44,236,179, 39,192,229,228,133, 87, 53,234, 12,174, 65,
         35,239,107,147, 69, 25,165, 33,237, 14, 79, 78, 29,101,146,189,
        134,184,175,143,124,235, 31,206, 62, 48,220, 95, 94,197, 11, 26,
        166,225, 57,202,213, 71, 93, 61,217,  1, 90,214, 81, 86,108, 77,
        139, 13,154,102,251,204,176, 45,116, 18, 43, 32,240,177,132,153,
        223, 76,203,194, 52,126,118,  5,109,183,169, 49,209, 23,  4,215,
         20, 88, 58, 97,222, 27, 17, 28, 50, 15,156, 22, 83, 24,242, 34,
        254, 68,207,178,195,181,122,145, 36,  8,232,168, 96,252,105, 80,
        170,208,160,125,161,137, 98,151, 84, 91, 30,149,224,255,100,210,
         16,196,  0, 72,163,247,117,219,138,  3,230,218,  9, 63,221,148,
        135, 92,131,  2,205, 74,144, 51,115,103,246,243,157,127,191,226,
         82,155,216, 38,200, 55,198, 59,129,150,111, 75, 19,190, 99, 46,
        233,121,167,140,159,110,188,142, 41,245,249,182, 47,253,180, 89,
        120,152,  6,106,231, 70,113,186,212, 37,171, 66,136,162,141,250,
        114,  7,185, 85,248,238,172, 10, 54, 73, 42,104, 60, 56,241,164,
         64, 40,211,123,187,201, 67,193, 21,227,173,244,119,199,128,158
    };

    always #5 clk = ~clk;

    camellia_sbox_bank #(.LANES(8), .OUT_REG(1), .FIXED_MAP(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(v_m), .in_ready(ir_m), .in_data(in_data), .in_sel(in_sel),
        .out_valid(ov_m), .out_ready(out_ready), .out_data(od_m));
    camellia_sbox_bank #(.LANES(8), .OUT_REG(0), .FIXED_MAP(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(v_z), .in_ready(ir_z), .in_data(in_data), .in_sel(in_sel),
        .out_valid(ov_z), .out_ready(out_ready), .out_data(od_z));
    camellia_sbox_bank #(.LANES(8), .OUT_REG(1), .FIXED_MAP(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(v_f), .in_ready(ir_f), .in_data(in_data), .in_sel(in_sel),
        .out_valid(ov_f), .out_ready(out_ready), .out_data(od_f));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] s1f(input logic [7:0] x);
        return 8'(sb[x]);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v);
        return 8'((v << 1) | (v >> 7));
    endfunction

    function automatic logic [7:0] rr(input logic [7:0] v);
        return 8'((v >> 1) | (v << 7));
    endfunction

    function automatic logic [63:0] model(input logic [63:0] d, input logic [15:0] s);
        logic [63:0] r;
        logic [7:0]  x;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            x = d[8*i +: 8];
            case (s[2*i +: 2])
                2'd0:    r[8*i +: 8] = s1f(x);
                2'd1:    r[8*i +: 8] = rl(s1f(x));
                2'd2:    r[8*i +: 8] = rr(s1f(x));
                default: r[8*i +: 8] = s1f(rl(x));
            endcase
        end
        return r;
    endfunction

    initial begin
        int st0, st1, st2, sent, rcvd, done_cyc;
        logic stalled_prev;
        logic [63:0] held;
        // reset
        tick();
        tick();
        chk("rst_ov_m", 64'(ov_m), 0);
        chk("rst_od_m", od_m, 0);
        chk("rst_ov_z", 64'(ov_z), 0);
        chk("rst_od_f", od_f, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ir_m", 64'(ir_m), 1);
        chk("rst_ir_z", 64'(ir_z), 1);
        chk("rst_ir_f", 64'(ir_f), 1);
        // basic s1 lookup and latency 2
        v_m = 1'b1;
        in_data = 64'hF0AA5510_FF800100;
        in_sel = '0;
        tick();
        v_m = 1'b0;
        chk("t1_early", 64'(ov_m), 0);
        tick();
        chk("t1_valid", 64'(ov_m), 1);
        chk("t1_data", od_m, 64'h40F67E23_9EAA8270);
        tick();
        chk("t1_idle", 64'(ov_m), 0);
        // per-lane box select, back to back
        v_m = 1'b1;
        in_sel = 16'hE4E4;
        in_data = 64'h0;
        tick();
        in_data = {8{8'h01}};
        tick();
        v_m = 1'b0;
        chk("mode00_valid", 64'(ov_m), 1);
        chk("mode00_data", od_m, 64'h7038E070_7038E070);
        tick();
        chk("mode01_valid", 64'(ov_m), 1);
        chk("mode01_data", od_m, 64'h2C410582_2C410582);
        tick();
        // fixed F-function map ignores in_sel
        v_f = 1'b1;
        in_data = 64'h0;
        in_sel = 16'($urandom);
        tick();
        in_data = {8{8'h01}};
        in_sel = 16'($urandom);
        tick();
        v_f = 1'b0;
        chk("fix00_valid", 64'(ov_f), 1);
        chk("fix00_data", od_f, 64'h707038E0_7038E070);
        tick();
        chk("fix01_data", od_f, 64'h822C4105_2C410582);
        tick();
        // 256-beat stream with three 5-cycle stalls
        st0 = $urandom_range(10, 60);
        st1 = st0 + $urandom_range(40, 80);
        st2 = st1 + $urandom_range(40, 80);
        sent = 0;
        rcvd = 0;
        done_cyc = -1;
        stalled_prev = 1'b0;
        held = '0;
        in_sel = 16'hE4E4;
        for (int c = 0; c < 1000 && rcvd < 256; c++) begin
            out_ready = !((c >= st0 && c < st0 + 5) || (c >= st1 && c < st1 + 5) || (c >= st2 && c < st2 + 5));
            v_m = (sent < 256);
            in_data = {8{8'(sent)}};
            #1;
            if (stalled_prev) begin
                chk("stall_hold_data", od_m, held);
                chk("stall_hold_valid", 64'(ov_m), 1);
            end
            if (c == st0 + 2 || c == st1 + 2 || c == st2 + 2) chk("full_ready", 64'(ir_m), 0);
            if (c >= 2) chk("stream_valid", 64'(ov_m), 1);
            stalled_prev = ov_m && !out_ready;
            held = od_m;
            if (ov_m && out_ready) begin
                chk("stream_data", od_m, model({8{8'(rcvd)}}, 16'hE4E4));
                rcvd++;
                if (rcvd == 256) done_cyc = c;
            end
            if (v_m && ir_m) sent++;
            tick();
        end
        v_m = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 64'(sent), 256);
        chk("stream_rcvd", 64'(rcvd), 256);
        chk("stream_cycles", 64'(done_cyc), 272);
        tick();
        chk("stream_drained", 64'(ov_m), 0);
        // OUT_REG=0 sweep, latency 1
        in_sel = 16'h1B1B;
        for (int j = 0; j <= 256; j++) begin
            v_z = (j < 256);
            in_data = {8{8'(j)}};
            if (j > 0) begin
                chk("z_valid", 64'(ov_z), 1);
                chk("z_data", od_z, model({8{8'(j - 1)}}, 16'h1B1B));
            end
            tick();
        end
        chk("z_idle", 64'(ov_z), 0);
        // reset with two beats in flight
        out_ready = 1'b0;
        in_sel = '0;
        v_m = 1'b1;
        in_data = {8{8'h01}};
        tick();
        in_data = {8{8'h80}};
        tick();
        v_m = 1'b0;
        chk("pre_rst_valid", 64'(ov_m), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(ov_m), 0);
        chk("mid_rst_data", od_m, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_quiet", 64'(ov_m), 0);
        end
        v_m = 1'b1;
        in_data = {8{8'hFF}};
        tick();
        v_m = 1'b0;
        tick();
        chk("post_rst_valid", 64'(ov_m), 1);
        chk("post_rst_data", od_m, {8{8'h9E}});
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/camellia_sbox_bank.md
Name: camellia_sbox_bank

Overview:
Parametrised multi-lane Camellia S-box lookup engine, the successor to the fixed dual-port SBOX_1 ROM. It serves LANES independent byte lookups per beat. Each lane selects s1, s2, s3 or s4; s2–s4 are derived from a single s1 table. The datapath is pipelined with a valid/ready handshake and full backpressure, and feeds the F-function and key-schedule datapaths.

Parameters:
LANES, 8, number of byte lanes per beat (1..16).
OUT_REG, 1, 0 = latency 1 (ROM register only); 1 = latency 2 (extra output register stage).
FIXED_MAP, 0, 0 = per-lane runtime select from in_sel; 1 = in_sel ignored, lane i uses the F-function pattern [s1,s2,s3,s4,s2,s3,s4,s1] indexed by i mod 8.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst_n  in  1  synchronous reset, active-low.
in_valid  in  1  input beat valid.
in_ready  out  1  engine can accept a beat this cycle.
in_data  in  8*LANES  lane i = in_data[8i+7:8i].
in_sel  in  2*LANES  lane i select = in_sel[2i+1:2i]: 0=s1, 1=s2, 2=s3, 3=s4.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts beat.
out_data  out  8*LANES  lane i result = out_data[8i+7:8i].

Behaviour:
- Reset: sampled on a clk edge with rst_n=0. All stage valid flags clear, out_valid=0, out_data=0. in_ready=1 in the first cycle after reset releases. Reset mid-stream discards every in-flight beat; no partial beat is emitted.
- Tables: s1 is the standard Camellia SBOX1, 256 entries, ROM.
  - s2(x) = rotl1(s1(x)).
  - s3(x) = rotr1(s1(x)).
  - s4(x) = s1(rotl1(x)).
  - Derivation is a pre-ROM address rotate for s4 and a post-ROM rotate for s2/s3. No separate tables.
- Stage 1 register: captures ROM output plus a per-lane "rotate mode" for the selected box, or performs the rotate before the register. Either choice is allowed, but the result must match the rules above. in_sel is sampled with in_data in the same beat.
- Stage 2: present only when OUT_REG=1. A plain register of the stage-1 result.
- Handshake:
  - A beat transfers when valid && ready.
  - Each stage advances when it is empty or when the stage downstream accepts.
  - in_ready = !v_last || out_ready, propagated back through the stages. A combinational ready path is allowed.
- Throughput: one beat per clk while out_ready=1. Latency from input transfer to out_valid = 1 + OUT_REG cycles.
- Backpressure: while out_valid && !out_ready, out_data and out_valid hold stable. No beat is dropped or duplicated, and beat order is preserved. Once the pipeline is full, in_ready=0.
- Simultaneous accept at input and drain at output in the same cycle is legal and keeps full throughput.
- in_valid=0 cycles create bubbles; bubbles collapse whenever a downstream stage is stalled.
- With FIXED_MAP=1, in_sel is unused and the synthesised mapping is static.
- No X on outputs after reset, regardless of in_data or in_sel while in_valid=0.

Test Plan:
- Reset, then LANES=8, OUT_REG=1, all sel=0, in_data lanes = {00,01,80,FF,...}. Required: out_valid exactly 2 cycles after transfer, lanes = {70,82,AA,9E}.
- Mode check, in_data all lanes 00, sel lanes 0..3 = 0,1,2,3. Required: out = {70,E0,38,70}. Then in_data 01 on all lanes with the same sel. Required: {82,05,41,2C}.
- FIXED_MAP=1, in_data all 00, in_sel random. Required: lanes 0..7 = {70,E0,38,70,E0,38,70,70}.
- Streaming of 256 beats with lane value = beat index. Hold out_ready=0 for 5 cycles at random points. Required: in_ready drops once full, out_data stays stable while stalled, all 256 results are in order and match a reference model, and throughput is 1/cycle when unstalled.
- OUT_REG=0 sweep. Required: latency 1 and identical results to OUT_REG=1.
- Assert rst_n=0 for 1 cycle with 2 beats in flight. Required: next cycle out_valid=0 and out_data=0, neither beat appears afterward, and a new beat after reset returns the correct value.
